// File: rtl/boot_seq_pkg.sv
// Shared types and defaults for the boot stage sequencer.
// No logic, no latency, no flow control.
// Holds the FSM state enum, the default opcodes and the stage-width helper.
package boot_seq_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        RSTP = 1'b1
    } state_t;

    localparam logic [5:0] HALT_OPC_DEF = 6'b011000;
    localparam logic [5:0] CK_BASE_DEF  = 6'b011101;

    // Index width for n stages; a single-stage index still needs one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/boot_pulse_timer.sv
// Loadable down-counter used for the CPU reset pulse and the boot watchdog.
// Latency: done/busy reflect the count register, one cycle after load.
// No backpressure: load overrides counting, and counting stops at zero.
module boot_pulse_timer #(
    parameter int           W       = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done,
    output logic         busy
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);
    assign busy = !done;

endmodule

// File: rtl/boot_stage_sequencer.sv
// Boot instruction-source sequencer: muxes src[stage] to the CPU, decodes HALT/check opcodes, and pulses cpu_reset.
// Latency: instr_out is combinational; stage, flags and cpu_reset update one edge after the decoding edge.
// No backpressure. The optional watchdog is compiled in with BOOT_WATCHDOG_EN.
module boot_stage_sequencer
    import boot_seq_pkg::*;
#(
    parameter int               DATA_W     = 32,
    parameter int               OPC_W      = 6,
    parameter int               NUM_STAGES = 2,
    parameter int               NUM_CK     = 3,
    parameter logic [OPC_W-1:0] HALT_OPC   = OPC_W'(HALT_OPC_DEF),
    parameter logic [OPC_W-1:0] CK_BASE    = OPC_W'(CK_BASE_DEF),
    parameter int               RST_CYCLES = 4,
    parameter int               WDT_CYCLES = 1 << 20
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_STAGES*DATA_W-1:0]         src_instr,
    input  logic                                 reboot,
    output logic [DATA_W-1:0]                    instr_out,
    output logic [clog2_min1(NUM_STAGES)-1:0]    stage,
    output logic                                 is_boot,
    output logic [NUM_CK-1:0]                    ck_flags,
    output logic                                 cpu_reset,
    output logic                                 stage_adv,
    output logic                                 wdt_fired
);

    localparam int SW = clog2_min1(NUM_STAGES);
    localparam int RW = $clog2(RST_CYCLES + 1);

    state_t            state, state_nx;
    logic [SW-1:0]     stage_nx;
    logic [NUM_CK-1:0] ck_nx;
    logic              cpu_reset_nx;
    logic              adv_nx;
    logic              p_load, p_done, p_busy;
    logic              wdt_trip;
    logic              reboot_any;

    logic [OPC_W-1:0]  opc;
    logic [OPC_W:0]    ck_diff;
    logic              ck_hit, halt_hit;

    assign instr_out = src_instr[stage*DATA_W +: DATA_W];
    assign is_boot   = (stage != SW'(NUM_STAGES - 1));
    assign opc       = instr_out[DATA_W-1 -: OPC_W];
    // A one-bit-wider difference makes opcodes below CK_BASE wrap far above NUM_CK.
    assign ck_diff   = {1'b0, opc} - {1'b0, CK_BASE};
    assign ck_hit    = (ck_diff < (OPC_W+1)'(NUM_CK));
    assign halt_hit  = (opc == HALT_OPC);
    assign reboot_any = reboot | wdt_trip;

    always_comb begin
        state_nx     = state;
        stage_nx     = stage;
        ck_nx        = '0;
        cpu_reset_nx = cpu_reset;
        adv_nx       = 1'b0;
        p_load       = 1'b0;
        if (reboot_any) begin
            state_nx     = RSTP;
            stage_nx     = '0;
            cpu_reset_nx = 1'b1;
            p_load       = 1'b1;
            adv_nx       = (stage != '0);
        end else begin
            case (state)
                RUN: begin
                    if (is_boot) begin
                        if (halt_hit) begin
                            state_nx     = RSTP;
                            stage_nx     = stage + 1'b1;
                            cpu_reset_nx = 1'b1;
                            adv_nx       = 1'b1;
                            p_load       = 1'b1;
                        end else if (ck_hit) begin
                            ck_nx = NUM_CK'(1) << ck_diff;
                        end
                    end
                end
                RSTP: begin
                    if (p_done) begin
                        state_nx     = RUN;
                        cpu_reset_nx = 1'b0;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            stage     <= '0;
            ck_flags  <= '0;
            cpu_reset <= 1'b0;
            stage_adv <= 1'b0;
        end else begin
            state     <= state_nx;
            stage     <= stage_nx;
            ck_flags  <= ck_nx;
            cpu_reset <= cpu_reset_nx;
            stage_adv <= adv_nx;
        end
    end

    // Loaded with RST_CYCLES-1 so cpu_reset stays high for exactly RST_CYCLES edges.
    boot_pulse_timer #(
        .W       (RW),
        .RST_VAL ('0)
    ) u_pulse (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (p_load),
        .load_val (RW'(RST_CYCLES - 1)),
        .en       ((state == RSTP) && p_busy),
        .done     (p_done),
        .busy     (p_busy)
    );

`ifdef BOOT_WATCHDOG_EN
    localparam int WW = $clog2(WDT_CYCLES + 1);

    logic w_done, w_busy, w_run, wdt_q;

    // Counts down from WDT_CYCLES-1; every stage change or reboot reloads it.
    assign w_run    = (state == RUN) && is_boot;
    assign wdt_trip = w_run && w_done;

    boot_pulse_timer #(
        .W       (WW),
        .RST_VAL (WW'(WDT_CYCLES - 1))
    ) u_wdt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (p_load),
        .load_val (WW'(WDT_CYCLES - 1)),
        .en       (w_run && w_busy),
        .done     (w_done),
        .busy     (w_busy)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdt_q <= 1'b0;
        end else if (wdt_trip && !reboot) begin
            wdt_q <= 1'b1;
        end
    end

    assign wdt_fired = wdt_q;
`else
    assign wdt_trip  = 1'b0;
    assign wdt_fired = 1'b0;
`endif

endmodule

// File: tb/tb_boot_stage_sequencer.sv
// Directed bench: a default 2-stage instance and a 3-stage instance with a 16-cycle watchdog.
// Watchdog expectations follow BOOT_WATCHDOG_EN.
module tb_boot_stage_sequencer;

    localparam logic [5:0] HALT = 6'b011000;
    localparam logic [5:0] CKB  = 6'b011101;
    localparam logic [5:0] NOP  = 6'b000001;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [63:0] src_a = '0;
    logic        reboot_a = 1'b0;
    logic [31:0] instr_a;
    logic [0:0]  stage_a;
    logic        boot_a, cpu_a, adv_a, wdt_a;
    logic [2:0]  ck_a;

    logic [95:0] src_b = '0;
    logic        reboot_b = 1'b0;
    logic [31:0] instr_b;
    logic [1:0]  stage_b;
    logic        boot_b, cpu_b, adv_b, wdt_b;
    logic [2:0]  ck_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    boot_stage_sequencer u_a (
        .clk(clk), .reset_n(reset_n), .src_instr(src_a), .reboot(reboot_a),
        .instr_out(instr_a), .stage(stage_a), .is_boot(boot_a), .ck_flags(ck_a),
        .cpu_reset(cpu_a), .stage_adv(adv_a), .wdt_fired(wdt_a)
    );

    boot_stage_sequencer #(.NUM_STAGES(3), .WDT_CYCLES(16)) u_b (
        .clk(clk), .reset_n(reset_n), .src_instr(src_b), .reboot(reboot_b),
        .instr_out(instr_b), .stage(stage_b), .is_boot(boot_b), .ck_flags(ck_b),
        .cpu_reset(cpu_b), .stage_adv(adv_b), .wdt_fired(wdt_b)
    );

    function automatic logic [31:0] w(input logic [5:0] o, input logic [25:0] p);
        return {o, p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_stage", 64'(stage_a), 64'd0);
        chk("rst_cpu",   64'(cpu_a),   64'd0);
        chk("rst_ck",    64'(ck_a),    64'd0);
        chk("rst_adv",   64'(adv_a),   64'd0);
        chk("rst_wdt",   64'(wdt_a),   64'd0);
        chk("rst_boot",  64'(boot_a),  64'd1);

        // T1: check opcode, HALT, 4-cycle pulse, final stage passes HALT
        src_a = {w(NOP, 26'h11), w(CKB + 6'd1, 26'h10)};
        src_b = {w(NOP, 26'h22), w(NOP, 26'h21), w(NOP, 26'h20)};
        rst();
        tick();
        chk("t1_ck1",    64'(ck_a),    64'd2);
        chk("t1_instr0", 64'(instr_a), 64'(w(CKB + 6'd1, 26'h10)));
        src_a[31:0] = w(HALT, 26'h10);
        tick();
        chk("t1_stage",  64'(stage_a), 64'd1);
        chk("t1_adv",    64'(adv_a),   64'd1);
        chk("t1_cpu0",   64'(cpu_a),   64'd1);
        chk("t1_ckclr",  64'(ck_a),    64'd0);
        chk("t1_instr1", 64'(instr_a), 64'(w(NOP, 26'h11)));
        chk("t1_boot",   64'(boot_a),  64'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t1_cpu_hi", 64'(cpu_a), 64'd1);
            chk("t1_adv_lo", 64'(adv_a), 64'd0);
        end
        tick();
        chk("t1_cpu_end", 64'(cpu_a), 64'd0);
        src_a[63:32] = w(HALT, 26'h11);
        tick();
        chk("t1_fin_stage", 64'(stage_a), 64'd1);
        chk("t1_fin_adv",   64'(adv_a),   64'd0);
        chk("t1_fin_cpu",   64'(cpu_a),   64'd0);
        src_a[63:32] = w(CKB, 26'h11);
        tick();
        chk("t1_fin_ck",    64'(ck_a),    64'd0);

        // T3: reboot from stage 1, HALT ignored in RSTP, reboot beats HALT
        reboot_a = 1'b1;
        tick();
        reboot_a = 1'b0;
        chk("t3_rb_stage", 64'(stage_a), 64'd0);
        chk("t3_rb_adv",   64'(adv_a),   64'd1);
        chk("t3_rb_cpu",   64'(cpu_a),   64'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t3_rstp_stage", 64'(stage_a), 64'd0);
            chk("t3_rstp_cpu",   64'(cpu_a),   64'd1);
        end
        tick();
        chk("t3_run_cpu",   64'(cpu_a),   64'd0);
        chk("t3_run_stage", 64'(stage_a), 64'd0);
        reboot_a = 1'b1;
        tick();
        reboot_a = 1'b0;
        src_a[31:0] = w(NOP, 26'h10);
        chk("t3_both_stage", 64'(stage_a), 64'd0);
        chk("t3_both_adv",   64'(adv_a),   64'd0);
        chk("t3_both_cpu",   64'(cpu_a),   64'd1);
        for (int i = 1; i < 4; i++) tick();
        chk("t3_restart_hi", 64'(cpu_a), 64'd1);
        tick();
        chk("t3_restart_lo", 64'(cpu_a), 64'd0);

        // T4: async reset during the second pulse cycle
        src_a[31:0] = w(HALT, 26'h10);
        tick();
        src_a[31:0] = w(NOP, 26'h10);
        chk("t4_stage1", 64'(stage_a), 64'd1);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("t4_async_cpu",   64'(cpu_a),   64'd0);
        chk("t4_async_stage", 64'(stage_a), 64'd0);
        chk("t4_async_adv",   64'(adv_a),   64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t4_rel_stage", 64'(stage_a), 64'd0);
        chk("t4_rel_cpu",   64'(cpu_a),   64'd0);
        src_a[31:0] = w(HALT, 26'h10);
        tick();
        chk("t4_run_halt", 64'(stage_a), 64'd1);

        // T5: check-range boundaries
        src_a[31:0] = w(CKB + 6'd2, 26'h10);
        rst();
        tick();
        chk("t5_ck2", 64'(ck_a), 64'd4);
        src_a[31:0] = w(CKB + 6'd3, 26'h10);
        tick();
        chk("t5_above", 64'(ck_a), 64'd0);
        src_a[31:0] = w(CKB, 26'h10);
        tick();
        chk("t5_ck0", 64'(ck_a), 64'd1);
        src_a[31:0] = w(CKB - 6'd1, 26'h10);
        tick();
        chk("t5_below", 64'(ck_a), 64'd0);

        // T2: three stages, no advance past the final one
        src_b = {w(HALT, 26'h22), w(HALT, 26'h21), w(HALT, 26'h20)};
        rst();
        tick();
        chk("t2_s1",     64'(stage_b), 64'd1);
        chk("t2_s1_adv", 64'(adv_b),   64'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("t2_s1_run", 64'(cpu_b),   64'd0);
        chk("t2_s1_hold", 64'(stage_b), 64'd1);
        tick();
        chk("t2_s2",      64'(stage_b), 64'd2);
        chk("t2_s2_adv",  64'(adv_b),   64'd1);
        chk("t2_s2_boot", 64'(boot_b),  64'd0);
        chk("t2_s2_cpu",  64'(cpu_b),   64'd1);
        for (int i = 0; i < 6; i++) tick();
        chk("t2_fin_stage", 64'(stage_b), 64'd2);
        chk("t2_fin_adv",   64'(adv_b),   64'd0);
        chk("t2_fin_cpu",   64'(cpu_b),   64'd0);
        chk("t2_fin_instr", 64'(instr_b), 64'(w(HALT, 26'h22)));

        // T6: watchdog
        src_b = {w(NOP, 26'h22), w(NOP, 26'h21), w(NOP, 26'h20)};
        rst();
`ifdef BOOT_WATCHDOG_EN
        for (int i = 0; i < 15; i++) tick();
        chk("t6_pre_wdt", 64'(wdt_b), 64'd0);
        chk("t6_pre_cpu", 64'(cpu_b), 64'd0);
        tick();
        chk("t6_fire_wdt",   64'(wdt_b),   64'd1);
        chk("t6_fire_cpu",   64'(cpu_b),   64'd1);
        chk("t6_fire_stage", 64'(stage_b), 64'd0);
        chk("t6_fire_adv",   64'(adv_b),   64'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("t6_sticky", 64'(wdt_b), 64'd1);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("t6_off_wdt", 64'(wdt_b), 64'd0);
        chk("t6_off_cpu", 64'(cpu_b), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
